// File: rtl/bank_group_cmd_issuer.sv
// rtl/bank_group_cmd_issuer.sv - DDR bank-group PRE/ACT/RD/WR issuer with tRP/tRCD/tCCD spacing.
// Define CLOSED_PAGE_EN to precharge the bank after every RD/WR; default is open-page.
module bank_group_cmd_issuer #(
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int TRP       = 4,
  parameter int TRCD      = 4,
  parameter int TCCD      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 halt,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic [18:0]          commands,
  output logic [BAWIDTH-1:0]   ba,
  output logic [ADDRWIDTH-1:0] row,
  output logic [COLWIDTH-1:0]  column
);

  localparam int BANKS = 2 ** BAWIDTH;
  localparam int TMAX  = (TRP > TRCD) ? TRP : TRCD;
  localparam int WW    = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int CW    = $clog2(TCCD);

  localparam logic [WW-1:0] RP_LOAD  = (TRP > 1) ? WW'(TRP - 2) : '0;
  localparam logic [WW-1:0] RCD_LOAD = (TRCD > 1) ? WW'(TRCD - 2) : '0;
  localparam logic [CW-1:0] CCD_LOAD = CW'(TCCD - 1);

  localparam logic [18:0] CMD_ACT = 19'd1;
  localparam logic [18:0] CMD_PRE = 19'd2;
  localparam logic [18:0] CMD_RD  = 19'd4;
  localparam logic [18:0] CMD_WR  = 19'd8;

  typedef enum logic [2:0] {
    IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RDWR
  } state_t;

`ifdef CLOSED_PAGE_EN
  localparam state_t AFTER_RP   = IDLE;
  localparam state_t AFTER_RDWR = PRE;
`else
  localparam state_t AFTER_RP   = ACT;
  localparam state_t AFTER_RDWR = IDLE;
`endif

  state_t                 state, state_d;
  logic [WW-1:0]          wait_cnt, wait_d;
  logic [CW-1:0]          ccd_cnt, ccd_d;
  logic [18:0]            cmd_d;
  logic                   accept;
  logic                   issue_act, issue_pre, issue_rw;

  logic                   lat_we;
  logic [BAWIDTH-1:0]     lat_ba;
  logic [ADDRWIDTH-1:0]   lat_row;
  logic [COLWIDTH-1:0]    lat_col;

  logic [BANKS-1:0]       bank_open;
  logic [ADDRWIDTH-1:0]   bank_row [BANKS];

  assign req_ready = (state == IDLE) && !halt && !reset;

  always_comb begin
    state_d   = state;
    wait_d    = wait_cnt;
    ccd_d     = ccd_cnt;
    cmd_d     = '0;
    accept    = 1'b0;
    issue_act = 1'b0;
    issue_pre = 1'b0;
    issue_rw  = 1'b0;
    // halt freezes every counter and the state; commands stay NOP
    if (!halt) begin
      if (ccd_cnt != '0) ccd_d = ccd_cnt - CW'(1);
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            accept = 1'b1;
            if (!bank_open[req_ba])                 state_d = ACT;
            else if (bank_row[req_ba] == req_row)   state_d = RDWR;
            else                                    state_d = PRE;
          end
        end
        PRE: begin
          cmd_d     = CMD_PRE;
          issue_pre = 1'b1;
          if (TRP > 1) begin
            state_d = WAIT_RP;
            wait_d  = RP_LOAD;
          end else begin
            state_d = AFTER_RP;
          end
        end
        WAIT_RP: begin
          if (wait_cnt == '0) state_d = AFTER_RP;
          else                wait_d  = wait_cnt - WW'(1);
        end
        ACT: begin
          cmd_d     = CMD_ACT;
          issue_act = 1'b1;
          if (TRCD > 1) begin
            state_d = WAIT_RCD;
            wait_d  = RCD_LOAD;
          end else begin
            state_d = RDWR;
          end
        end
        WAIT_RCD: begin
          if (wait_cnt == '0) state_d = RDWR;
          else                wait_d  = wait_cnt - WW'(1);
        end
        RDWR: begin
          if (ccd_cnt == '0) begin
            cmd_d    = lat_we ? CMD_WR : CMD_RD;
            issue_rw = 1'b1;
            ccd_d    = CCD_LOAD;
            state_d  = AFTER_RDWR;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      ccd_cnt   <= '0;
      bank_open <= '0;
      commands  <= '0;
      ba        <= '0;
      row       <= '0;
      column    <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      ccd_cnt  <= ccd_d;
      commands <= cmd_d;
      if (issue_act || issue_pre || issue_rw) ba <= lat_ba;
      if (issue_act) begin
        row               <= lat_row;
        bank_open[lat_ba] <= 1'b1;
      end
      if (issue_pre) bank_open[lat_ba] <= 1'b0;
      if (issue_rw)  column <= lat_col;
    end
  end

  // Request fields and stored rows need no reset; bank_open qualifies the rows.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we  <= req_we;
      lat_ba  <= req_ba;
      lat_row <= req_row;
      lat_col <= req_col;
    end
    if (!reset && issue_act) bank_row[lat_ba] <= lat_row;
  end

endmodule

// File: tb/tb_bank_group_cmd_issuer.sv
// tb/tb_bank_group_cmd_issuer.sv - directed self-checking bench for bank_group_cmd_issuer.
// Define CLOSED_PAGE_EN to run the closed-page sequence instead of the open-page hit/miss tests.
module tb_bank_group_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset, halt, req_valid, req_ready, req_we;
  logic [1:0]  req_ba, ba;
  logic [16:0] req_row, row;
  logic [9:0]  req_col, column;
  logic [18:0] commands;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  bank_group_cmd_issuer dut (
    .clk(clk), .reset(reset), .halt(halt),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .commands(commands), .ba(ba), .row(row), .column(column)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; returns the edge number at which the request is taken.
  task automatic send(input logic we, input logic [1:0] b, input logic [16:0] r,
                      input logic [9:0] c, output int acc);
    acc       = -1;
    req_valid = 1'b1;
    req_we    = we;
    req_ba    = b;
    req_row   = r;
    req_col   = c;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin
        acc = cyc + 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (acc < 0) check("send timeout", 0, 1);
  endtask

  task automatic wait_cmd(input string tag, output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (commands != '0) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check({tag, " timeout"}, 0, 1);
  endtask

  int acc, c, prev, nz;

  initial begin
    reset = 1'b1; halt = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_ba = '0; req_row = '0; req_col = '0;

    // 1: reset
    repeat (3) begin
      @(negedge clk);
      check("rst commands", commands, 0);
      check("rst req_ready", req_ready, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("post-rst req_ready", req_ready, 1);
    check("post-rst commands", commands, 0);
    check("post-rst ba/row/col", {ba, row, column}, 0);

    // 2: closed bank read
    send(1'b0, 2'd1, 17'h10, 10'h20, acc);
    wait_cmd("t2 act", c);
    check("t2 act cycle", c - acc, 1);
    check("t2 act cmd", commands, 19'd1);
    check("t2 act ba", ba, 1);
    check("t2 act row", row, 17'h10);
    wait_cmd("t2 rd", c);
    check("t2 rd cycle", c - acc, 5);
    check("t2 rd cmd", commands, 19'd4);
    check("t2 rd column", column, 10'h20);
    prev = c;

`ifdef CLOSED_PAGE_EN
    // 6: closed page - PRE after RD, second read to the same row re-activates
    wait_cmd("t6 pre", c);
    check("t6 pre cycle", c - prev, 1);
    check("t6 pre cmd", commands, 19'd2);
    check("t6 pre ba", ba, 1);
    send(1'b0, 2'd1, 17'h10, 10'h28, acc);
    wait_cmd("t6 act", c);
    check("t6 act cycle", c - acc, 1);
    check("t6 act cmd", commands, 19'd1);
    wait_cmd("t6 rd", c);
    check("t6 rd cycle", c - acc, 5);
    check("t6 rd cmd", commands, 19'd4);
    check("t6 rd column", column, 10'h28);
    wait_cmd("t6 pre2", c);
    check("t6 pre2 cmd", commands, 19'd2);
`else
    // 3: row hit right after, spaced by tCCD
    send(1'b0, 2'd1, 17'h10, 10'h28, acc);
    wait_cmd("t3 rd", c);
    check("t3 rd cmd", commands, 19'd4);
    check("t3 tccd gap", c - prev, 4);
    check("t3 rd column", column, 10'h28);

    // open bank 2 so the miss on bank 1 can be shown not to disturb it
    send(1'b0, 2'd2, 17'h55, 10'h5, acc);
    wait_cmd("b2 act", c);
    check("b2 act cmd", commands, 19'd1);
    check("b2 act row", row, 17'h55);
    wait_cmd("b2 rd", c);
    check("b2 rd cycle", c - acc, 5);

    // 4: write miss on bank 1
    send(1'b1, 2'd1, 17'h11, 10'h30, acc);
    wait_cmd("t4 pre", c);
    check("t4 pre cycle", c - acc, 1);
    check("t4 pre cmd", commands, 19'd2);
    check("t4 pre ba", ba, 1);
    wait_cmd("t4 act", c);
    check("t4 act cycle", c - acc, 5);
    check("t4 act cmd", commands, 19'd1);
    check("t4 act row", row, 17'h11);
    wait_cmd("t4 wr", c);
    check("t4 wr cycle", c - acc, 9);
    check("t4 wr cmd", commands, 19'd8);
    check("t4 wr column", column, 10'h30);

    repeat (6) @(negedge clk);
    send(1'b0, 2'd2, 17'h55, 10'h6, acc);
    wait_cmd("b2 hit", c);
    check("b2 hit cycle", c - acc, 1);
    check("b2 hit cmd", commands, 19'd4);
    check("b2 hit ba", ba, 2);
    check("b2 hit column", column, 10'h6);
`endif

    // 5: halt for 3 cycles during WAIT_RCD
    repeat (8) @(negedge clk);
    send(1'b0, 2'd3, 17'h7, 10'h9, acc);
    wait_cmd("t5 act", c);
    check("t5 act cycle", c - acc, 1);
    halt = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5 halt commands", commands, 0);
      check("t5 halt req_ready", req_ready, 0);
    end
    halt = 1'b0;
    wait_cmd("t5 rd", c);
    check("t5 rd cycle", c - acc, 8);
    check("t5 rd cmd", commands, 19'd4);
    check("t5 rd ba", ba, 3);

    // reset mid-operation drops the request and closes the bank
    repeat (8) @(negedge clk);
    send(1'b0, 2'd0, 17'h1, 10'h2, acc);
    wait_cmd("mr act", c);
    check("mr act cmd", commands, 19'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nz = 0;
    repeat (8) begin
      @(negedge clk);
      if (commands != '0) nz++;
    end
    check("mr no cmd after reset", nz, 0);
    send(1'b0, 2'd0, 17'h1, 10'h3, acc);
    wait_cmd("mr reopen", c);
    check("mr reopen act", commands, 19'd1);
    check("mr reopen cycle", c - acc, 1);
    wait_cmd("mr rd", c);
    check("mr rd cycle", c - acc, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
